// File: rtl/rs_encode_src_arb.sv
// Round-robin arbiter feeding one RS encoder from NUM_SRC line sources; a grant lasts a whole job.
// Optional per-source completed-job counters enabled by RS_ENCODE_ARB_STATS_EN.
module rs_encode_src_arb #(
  parameter int NUM_SRC = 4,
  parameter int LINE_W  = 256,
  parameter int SRC_W   = $clog2(NUM_SRC)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_SRC-1:0]        src_arb_line_val,
  input  logic [NUM_SRC*LINE_W-1:0] src_arb_line,
  input  logic [NUM_SRC-1:0]        src_arb_line_last,
  output logic [NUM_SRC-1:0]        arb_src_line_rdy,
  output logic                      arb_encoder_line_val,
  output logic [LINE_W-1:0]         arb_encoder_line,
  output logic                      arb_encoder_line_last,
  input  logic                      encoder_arb_line_rdy,
  input  logic                      encoder_arb_job_done,
  output logic [SRC_W-1:0]          arb_out_job_src,
  output logic                      arb_out_job_val
`ifdef RS_ENCODE_ARB_STATS_EN
  ,
  output logic [NUM_SRC*16-1:0]     arb_stat_jobs
`endif
);

  typedef enum logic [1:0] {IDLE, STREAM, WAIT_DONE} state_t;

  state_t           state, state_nxt;
  logic [SRC_W-1:0] grant, rr_ptr, pick;
  logic             pick_val;
  logic             xfer;

  // First requester at or above rr_ptr, wrapping back to 0.
  always_comb begin
    int unsigned idx;
    idx      = 0;
    pick     = '0;
    pick_val = 1'b0;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      idx = (int'(rr_ptr) + k) % NUM_SRC;
      if (!pick_val && src_arb_line_val[idx]) begin
        pick_val = 1'b1;
        pick     = SRC_W'(idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grant  <= '0;
      rr_ptr <= '0;
    end else begin
      if (state == IDLE && pick_val)
        grant <= pick;
      if (state == WAIT_DONE && encoder_arb_job_done)
        rr_ptr <= (grant == SRC_W'(NUM_SRC - 1)) ? '0 : grant + 1'b1;
    end
  end

  assign xfer = arb_encoder_line_val & encoder_arb_line_rdy;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (pick_val) state_nxt = STREAM;
      STREAM:    if (xfer && arb_encoder_line_last) state_nxt = WAIT_DONE;
      WAIT_DONE: if (encoder_arb_job_done) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Outputs are gated by rst so everything reads idle while reset is held.
  always_comb begin
    arb_src_line_rdy      = '0;
    arb_encoder_line_val  = 1'b0;
    arb_encoder_line      = '0;
    arb_encoder_line_last = 1'b0;
    arb_out_job_val       = 1'b0;
    arb_out_job_src       = grant;
    if (!rst) begin
      case (state)
        STREAM: begin
          arb_encoder_line_val   = src_arb_line_val[grant];
          arb_encoder_line       = src_arb_line[grant*LINE_W +: LINE_W];
          arb_encoder_line_last  = src_arb_line_last[grant];
          arb_src_line_rdy[grant] = encoder_arb_line_rdy;
          arb_out_job_val        = 1'b1;
        end
        WAIT_DONE: arb_out_job_val = 1'b1;
        default: ;
      endcase
    end
  end

`ifdef RS_ENCODE_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      arb_stat_jobs <= '0;
    end else if (state == WAIT_DONE && encoder_arb_job_done &&
                 arb_stat_jobs[grant*16 +: 16] != 16'hFFFF) begin
      arb_stat_jobs[grant*16 +: 16] <= arb_stat_jobs[grant*16 +: 16] + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rs_encode_src_arb.sv
// Directed bench for rs_encode_src_arb: per-source line stores drive requests, a queue of
// expected encoder-side transfers is checked on every handshake. Stats checked if RS_ENCODE_ARB_STATS_EN.
module tb_rs_encode_src_arb;
  localparam int NS = 4;
  localparam int LW = 32;
  localparam int SW = 2;

  typedef struct packed {
    logic [SW-1:0] src;
    logic [LW-1:0] line;
    logic          last;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [NS-1:0]     sval, slast, srdy;
  logic [NS*LW-1:0]  sline;
  logic              eval, elast, erdy, jdone, jval;
  logic [LW-1:0]     eline;
  logic [SW-1:0]     jsrc;
`ifdef RS_ENCODE_ARB_STATS_EN
  logic [NS*16-1:0]  stats;
`endif

  always #5 clk = ~clk;

  rs_encode_src_arb #(.NUM_SRC(NS), .LINE_W(LW)) dut (
    .clk(clk), .rst(rst),
    .src_arb_line_val(sval), .src_arb_line(sline), .src_arb_line_last(slast),
    .arb_src_line_rdy(srdy),
    .arb_encoder_line_val(eval), .arb_encoder_line(eline), .arb_encoder_line_last(elast),
    .encoder_arb_line_rdy(erdy), .encoder_arb_job_done(jdone),
    .arb_out_job_src(jsrc), .arb_out_job_val(jval)
`ifdef RS_ENCODE_ARB_STATS_EN
    , .arb_stat_jobs(stats)
`endif
  );

  logic [LW-1:0] mem   [NS][8];
  logic          mlast [NS][8];
  int unsigned   wr [NS];
  int unsigned   rd [NS];
  exp_t          expq[$];
  int unsigned   xq[$];
  int            total = 0;
  int            bad = 0;
  int unsigned   cyc = 0;
  int            done_cnt = 0;
  logic [NS-1:0] gap;
  logic          spur, use_pat, prev_jval;
  logic [7:0]    rpat;
  int unsigned   rpi;
  logic [SW-1:0] prev_src;
  int            idle_run, last_idle;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic add_job(input int s, input int n, input int base);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      mem[s][wr[s] % 8]   = LW'(base + k);
      mlast[s][wr[s] % 8] = (k == n - 1);
      wr[s]++;
      e.src  = SW'(s);
      e.line = LW'(base + k);
      e.last = (k == n - 1);
      expq.push_back(e);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < NS; i++) begin
      if (rd[i] < wr[i] && !gap[i]) begin
        sval[i] = 1'b1;
        sline[i*LW +: LW] = mem[i][rd[i] % 8];
        slast[i] = mlast[i][rd[i] % 8];
      end else begin
        sval[i] = 1'b0;
        slast[i] = 1'b0;
        sline[i*LW +: LW] = '0;
      end
    end
    erdy  = use_pat ? rpat[rpi % 8] : 1'b1;
    rpi++;
    jdone = (done_cnt == 1) || spur;
  endtask

  task automatic monitor();
    logic          xfer;
    logic [NS-1:0] m;
    exp_t          e;
    xfer = eval & erdy;
    m = '0;
    m[jsrc] = 1'b1;
    if (jval) begin
      chk("rdy_excl", srdy & ~m, 0);
      chk("src_hs", srdy[jsrc] & sval[jsrc], xfer);
      if (prev_jval) chk("src_stable", jsrc, prev_src);
      if (done_cnt > 0) chk("wd_val", eval, 0);
      if (!prev_jval) begin
        last_idle = idle_run;
        idle_run  = 0;
      end
    end else begin
      chk("rdy_idle", srdy, 0);
      chk("val_idle", eval, 0);
      idle_run++;
    end
    if (xfer) begin
      chk("xfer_unexp", expq.size() > 0, 1);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("xfer_src", jsrc, e.src);
        chk("xfer_line", eline, e.line);
        chk("xfer_last", elast, e.last);
      end
      rd[jsrc]++;
      xq.push_back(cyc + 1);
      if (elast) done_cnt = 3;
    end
    prev_jval = jval;
    prev_src  = jsrc;
  endtask

  task automatic step();
    drive();
    @(negedge clk);
    monitor();
    @(posedge clk);
    cyc++;
    if (done_cnt > 0) done_cnt--;
    #1;
  endtask

  function automatic logic quiet();
    logic q;
    q = (expq.size() == 0) && (done_cnt == 0) && !jval;
    for (int i = 0; i < NS; i++) if (rd[i] != wr[i]) q = 1'b0;
    return q;
  endfunction

  task automatic run(input string tag, input int maxc);
    int n;
    n = 0;
    while (!quiet() && n < maxc) begin
      step();
      n++;
    end
    chk({"timeout_", tag}, quiet(), 1);
  endtask

  initial begin
    int unsigned rc;
    int n;
    rst = 1'b1; sval = '0; slast = '0; sline = '0; erdy = 1'b1; jdone = 1'b0;
    gap = '0; spur = 1'b0; use_pat = 1'b0; rpat = 8'b0101_0101; rpi = 0;
    prev_jval = 1'b0; prev_src = '0; idle_run = 0; last_idle = -1;
    for (int i = 0; i < NS; i++) begin wr[i] = 0; rd[i] = 0; end

    // reset state
    step(); step();
    chk("rst_val", eval, 0);
    chk("rst_rdy", srdy, 0);
    chk("rst_jval", jval, 0);
    rst = 1'b0;

    // sources 0 and 1 together from reset: 0 first, one idle cycle, then 1
    add_job(0, 2, 'h010);
    add_job(1, 2, 'h020);
    run("two_src", 40);
    chk("idle_gap", last_idle, 1);

    // lone 3-line job from source 2: transfers on edges +2,+3,+4
    xq.delete();
    rc = cyc;
    add_job(2, 3, 'h200);
    run("src2", 40);
    chk("lat_n", xq.size(), 3);
    for (int k = 0; k < 3; k++) chk("lat", (xq.size() > k) ? xq[k] : 0, rc + 2 + k);

    // rr_ptr=3: source 3 ahead of source 0, then wrap to 0
    add_job(3, 2, 'h300);
    add_job(0, 1, 'h030);
    run("wrap", 40);

    // encoder rdy toggling while source 2 also waits
    use_pat = 1'b1; rpi = 0;
    add_job(1, 2, 'h110);
    add_job(2, 1, 'h120);
    run("toggle", 40);
    use_pat = 1'b0;

    // granted source drops val mid-job; spurious done in STREAM ignored
    add_job(1, 3, 'h150);
    step(); step();
    add_job(0, 1, 'h050);
    gap[1] = 1'b1; spur = 1'b1;
    step();
    spur = 1'b0;
    step();
    chk("gap_hold", jsrc, 1);
    chk("gap_jval", jval, 1);
    gap[1] = 1'b0;
    run("gap", 40);

    // advance rr_ptr to 2, then reset mid-job of source 2
    add_job(1, 1, 'h160);
    run("pre_rst", 20);
    xq.delete();
    add_job(2, 4, 'h2A0);
    n = 0;
    while (xq.size() < 1 && n < 10) begin step(); n++; end
    chk("pre_rst_xfer", xq.size(), 1);
    rst = 1'b1;
    step();
    chk("mid_rst_val", eval, 0);
    chk("mid_rst_rdy", srdy, 0);
    chk("mid_rst_jval", jval, 0);
    expq.delete();
    rd[2] = wr[2];
    done_cnt = 0;
    rst = 1'b0;
    add_job(1, 1, 'h170);
    add_job(3, 1, 'h370);
    run("post_rst", 40);

`ifdef RS_ENCODE_ARB_STATS_EN
    rst = 1'b1;
    step();
    rst = 1'b0;
    add_job(1, 2, 'h180);
    add_job(1, 1, 'h190);
    add_job(1, 1, 'h1A0);
    run("stats", 60);
    for (int i = 0; i < NS; i++) chk("stat", stats[i*16 +: 16], (i == 1) ? 3 : 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
